// File: rtl/seq_divider_32x16_if.sv
// Operand/result handshake bundle for the sequential divider.
// The initiator uses the master modport, the divider uses the slave modport.
interface seq_divider_32x16_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
);
    // valid/ready: a transfer happens on a rising edge where both are high;
    // the source holds valid and data stable until then, ready never waits on valid.
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider_32x16.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock,
// one operation in flight, valid/ready on operand and result sides.
module seq_divider_32x16 #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_divider_32x16_if.slave   bus,
    output logic [1:0]           state_dbg
);
    localparam int CW = $clog2(DIVIDEND_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] shift_q, shift_d;
    logic [DIVIDEND_WIDTH-1:0] quot_q, quot_d;
    logic [DIVISOR_WIDTH-1:0]  dvsr_q, dvsr_d;
    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic                      dbz_q, dbz_d;

    // Trial subtract is one bit wider so a divisor of all ones cannot overflow.
    logic [DIVISOR_WIDTH:0]    trial_p;
    logic [DIVISOR_WIDTH:0]    trial_diff;
    logic                      trial_ge;

    always_comb begin
        trial_p    = {rem_q, shift_q[DIVIDEND_WIDTH-1]};
        trial_diff = trial_p - {1'b0, dvsr_q};
        trial_ge   = (trial_p >= {1'b0, dvsr_q});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    shift_d = bus.dividend;
                    dvsr_d  = bus.divisor;
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = bus.dividend[DIVISOR_WIDTH-1:0];
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        quot_d  = '0;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CW'(DIVIDEND_WIDTH - 1);
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                shift_d = {shift_q[DIVIDEND_WIDTH-2:0], 1'b0};
                quot_d  = {quot_q[DIVIDEND_WIDTH-2:0], trial_ge};
                rem_d   = trial_ge ? trial_diff[DIVISOR_WIDTH-1:0]
                                   : trial_p[DIVISOR_WIDTH-1:0];
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    dbz_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Handshake flags decode straight from state; results come from flops.
    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_seq_divider_32x16.sv
// Directed-vector and randomised bench for seq_divider_32x16.
module tb_seq_divider_32x16;
  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  seq_divider_32x16_if bus ();

  seq_divider_32x16 dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [48:0] exp_q[$];

  typedef struct {
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [31:0] exp_quot;
    logic [15:0] exp_rem;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] dd, input logic [15:0] dv,
                       input logic [31:0] eq, input logic [15:0] er, input logic edz);
    int n;
    @(negedge clk);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 200), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_q.push_back({eq, er, edz});
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int lat;
    logic [48:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 200);
    chk($sformatf("%s latency", name), 64'(lat), 64'(exp_lat));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s quotient", name), 64'(bus.quotient), 64'(e[48:17]));
      chk($sformatf("%s remainder", name), 64'(bus.remainder), 64'(e[16:1]));
      chk($sformatf("%s div_by_zero", name), 64'(bus.div_by_zero), 64'(e[0]));
    end else begin
      chk($sformatf("%s scoreboard_empty", name), 64'(exp_q.size()), 64'(1));
    end
    chk($sformatf("%s in_ready_busy", name), 64'(bus.in_ready), 64'(0));
  endtask

  task automatic take_result(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("%s in_ready_after", name), 64'(bus.in_ready), 64'(1));
    chk($sformatf("%s out_valid_after", name), 64'(bus.out_valid), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] q_hold;
    logic [15:0] r_hold;
    logic [31:0] rdd;
    logic [15:0] rdv;

    checks = 0;
    errors = 0;
    vecs[0]  = '{32'd1000,      16'd7,      32'd142,        16'd6,      1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 16'hFFFF,   32'h0001_0001,  16'h0000,   1'b0};
    vecs[2]  = '{32'hFFFF_FFFF, 16'h0001,   32'hFFFF_FFFF,  16'h0000,   1'b0};
    vecs[3]  = '{32'h1234_5678, 16'h0000,   32'hFFFF_FFFF,  16'h5678,   1'b1};
    vecs[4]  = '{32'd0,         16'd5,      32'd0,          16'd0,      1'b0};
    vecs[5]  = '{32'h8000_0000, 16'h8000,   32'h0001_0000,  16'h0000,   1'b0};
    vecs[6]  = '{32'hFFFF_FFFF, 16'd2,      32'h7FFF_FFFF,  16'd1,      1'b0};
    vecs[7]  = '{32'd1,         16'd1,      32'd1,          16'd0,      1'b0};
    vecs[8]  = '{32'h0000_FFFE, 16'hFFFF,   32'd0,          16'hFFFE,   1'b0};
    vecs[9]  = '{32'hDEAD_BEEF, 16'h0010,   32'h0DEA_DBEE,  16'h000F,   1'b0};
    vecs[10] = '{32'h0001_0000, 16'hFFFF,   32'd1,          16'd1,      1'b0};
    vecs[11] = '{32'h0000_0000, 16'h0000,   32'hFFFF_FFFF,  16'h0000,   1'b1};

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset state", 64'(state_dbg), 64'(0));
    chk("reset in_ready", 64'(bus.in_ready), 64'(1));
    chk("reset out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset quotient", 64'(bus.quotient), 64'(0));
    chk("reset remainder", 64'(bus.remainder), 64'(0));
    chk("reset div_by_zero", 64'(bus.div_by_zero), 64'(0));

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].dividend, vecs[i].divisor, vecs[i].exp_quot, vecs[i].exp_rem, vecs[i].exp_dbz);
      wait_result($sformatf("vec%0d", i), vecs[i].exp_dbz ? 1 : 33);
      take_result($sformatf("vec%0d", i));
    end

    // result held while out_ready stays low; new operands must be ignored
    issue(32'd5, 16'd9, 32'd0, 16'd5, 1'b0);
    wait_result("stall", 33);
    q_hold = bus.quotient;
    r_hold = bus.remainder;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (c < 6);
      bus.dividend = 32'd77;
      bus.divisor  = 16'd0;
      @(negedge clk);
      chk("stall out_valid", 64'(bus.out_valid), 64'(1));
      chk("stall in_ready", 64'(bus.in_ready), 64'(0));
      chk("stall quotient", 64'(bus.quotient), 64'(q_hold));
      chk("stall remainder", 64'(bus.remainder), 64'(r_hold));
      chk("stall div_by_zero", 64'(bus.div_by_zero), 64'(0));
    end
    bus.in_valid = 1'b0;
    take_result("stall");
    chk("stall back_to_idle", 64'(state_dbg), 64'(0));

    // reset in cycle 15 of a CALC discards the operation
    issue(32'hFFFF_FFFF, 16'd3, 32'h5555_5555, 16'd0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    chk("midcalc state_before", 64'(state_dbg), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midcalc state", 64'(state_dbg), 64'(0));
    chk("midcalc in_ready", 64'(bus.in_ready), 64'(1));
    chk("midcalc out_valid", 64'(bus.out_valid), 64'(0));
    chk("midcalc quotient", 64'(bus.quotient), 64'(0));
    chk("midcalc remainder", 64'(bus.remainder), 64'(0));
    issue(32'd100, 16'd10, 32'd10, 16'd0, 1'b0);
    wait_result("after_reset", 33);
    take_result("after_reset");

    // randomised operands with random gaps on both sides
    for (int k = 0; k < 150; k++) begin
      rdd = $urandom;
      case ($urandom_range(0, 3))
        0:       rdv = 16'd0;
        1:       rdv = 16'($urandom_range(1, 15));
        default: rdv = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if (rdv == 16'd0)
        issue(rdd, rdv, 32'hFFFF_FFFF, rdd[15:0], 1'b1);
      else
        issue(rdd, rdv, rdd / {16'd0, rdv}, 16'(rdd % {16'd0, rdv}), 1'b0);
      wait_result($sformatf("rand%0d", k), (rdv == 16'd0) ? 1 : 33);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      take_result($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
